// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and the
// bit-counter width rule.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // One extra bit over $clog2 so the counter can reach WIDTH-1 without wrapping,
    // including the WIDTH=1 case.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/adder.sv
// Single-bit full adder; the only arithmetic element in the serial datapath.
module adder (
    input  logic a,
    input  logic b,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ carry_in;
    assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts an operand pair, adds one bit per cycle LSB-first
// through a single full adder, then presents the result until it is taken.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_carry,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry
);

    localparam int             CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;
    logic             out_carry_q, out_carry_d;

    logic fa_sum;
    logic fa_carry;

    adder u_adder (
        .a         (a_q[0]),
        .b         (b_q[0]),
        .carry_in  (carry_q),
        .sum       (fa_sum),
        .carry_out (fa_carry)
    );

    // NOTE: every next-state signal takes its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sum_d       = sum_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_carry_d = out_carry_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    carry_d = in_carry;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d              = a_q >> 1;
                b_d              = b_q >> 1;
                sum_d            = sum_q >> 1;
                sum_d[WIDTH-1]   = fa_sum;
                carry_d          = fa_carry;
                cnt_d            = cnt_q + 1'b1;
                // Results go to separate output registers so they stay put
                // while the next operation shifts through the working registers.
                if (cnt_q == CNT_LAST) begin
                    out_sum_d   = sum_d;
                    out_carry_d = fa_carry;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is sampled on the clock edge and wins over any accept or completion in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_carry_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_carry_q <= out_carry_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign out_sum   = out_sum_q;
    assign out_carry = out_carry_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for the arithmetic,
// handshake, reset and throughput cases, and a 1-bit instance for the truth table.
module tb_serial_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       in_valid8 = 1'b0, in_ready8, in_carry8 = 1'b0;
    logic [7:0] in_a8 = '0, in_b8 = '0, out_sum8;
    logic       out_valid8, out_ready8 = 1'b0, out_carry8;

    logic       in_valid1 = 1'b0, in_ready1, in_carry1 = 1'b0;
    logic [0:0] in_a1 = '0, in_b1 = '0, out_sum1;
    logic       out_valid1, out_ready1 = 1'b0, out_carry1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .in_a      (in_a8),
        .in_b      (in_b8),
        .in_carry  (in_carry8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .out_sum   (out_sum8),
        .out_carry (out_carry8)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .in_a      (in_a1),
        .in_b      (in_b1),
        .in_carry  (in_carry1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .out_sum   (out_sum1),
        .out_carry (out_carry1)
    );

    task automatic check(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are read 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic [7:0] exp_s, input logic exp_c,
                           input int hold);
        int lat;
        in_a8 = a; in_b8 = b; in_carry8 = c;
        out_ready8 = 1'b0;
        in_valid8 = 1'b1;
        check({tag, "_ready"}, 33'(in_ready8), 33'd1);
        tick();
        in_valid8 = 1'b0;
        lat = 0;
        while (!out_valid8 && lat < 32) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 33'(lat), 33'd8);
        check({tag, "_sum"}, 33'(out_sum8), 33'(exp_s));
        check({tag, "_carry"}, 33'(out_carry8), 33'(exp_c));
        for (int i = 0; i < hold; i++) begin
            tick();
            check({tag, "_hold"}, {out_valid8, in_ready8, out_carry8, out_sum8},
                  {1'b1, 1'b0, exp_c, exp_s});
        end
        out_ready8 = 1'b1;
        tick();
        out_ready8 = 1'b0;
        check({tag, "_idle"}, {out_valid8, in_ready8}, 33'b01);
        check({tag, "_retain"}, {out_carry8, out_sum8}, {exp_c, exp_s});
    endtask

    initial begin
        logic [7:0] sum_tab;
        logic [7:0] carry_tab;
        int         seen;
        int         cyc, last_acc, n_acc, n_res;
        logic       accepting;
        logic [8:0] exp_q[$];
        logic [8:0] exp_v;

        // Reset state
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_ready8", 33'(in_ready8), 33'd1);
        check("rst_valid8", 33'(out_valid8), 33'd0);
        check("rst_out8", {out_carry8, out_sum8}, 33'd0);
        check("rst_hs1", {in_ready1, out_valid1}, 33'b10);

        // Directed arithmetic cases
        run_op8("op_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 0);
        run_op8("op_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 0);
        run_op8("op_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 0);
        run_op8("op_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 5);

        // Reset after three RUN cycles aborts the operation
        in_a8 = 8'hAA; in_b8 = 8'h55; in_carry8 = 1'b0;
        in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_ready", 33'(in_ready8), 33'd1);
        check("abort_valid", 33'(out_valid8), 33'd0);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid8) seen++;
        end
        check("abort_no_valid", 33'(seen), 33'd0);
        run_op8("op_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 0);

        // Back-to-back throughput with random operands
        out_ready8 = 1'b1;
        in_a8 = 8'($urandom); in_b8 = 8'($urandom); in_carry8 = 1'($urandom);
        in_valid8 = 1'b1;
        cyc = 0; last_acc = -1; n_acc = 0; n_res = 0;
        while (n_res < 100 && cyc < 3000) begin
            accepting = in_valid8 && in_ready8;
            if (accepting) exp_q.push_back({1'b0, in_a8} + {1'b0, in_b8} + 9'(in_carry8));
            tick();
            cyc++;
            if (accepting) begin
                if (last_acc >= 0) check("tp_spacing", 33'(cyc - last_acc), 33'd10);
                last_acc = cyc;
                n_acc++;
                in_a8 = 8'($urandom); in_b8 = 8'($urandom); in_carry8 = 1'($urandom);
                if (n_acc == 100) in_valid8 = 1'b0;
            end
            if (out_valid8) begin
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 9'h1FF;
                check("tp_result", {out_carry8, out_sum8}, 33'(exp_v));
                n_res++;
            end
        end
        check("tp_count", 33'(n_res), 33'd100);
        in_valid8 = 1'b0;
        out_ready8 = 1'b0;

        // WIDTH=1 truth table, index = {a, b, cin}
        sum_tab   = 8'b1001_0110;
        carry_tab = 8'b1110_1000;
        out_ready1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int lat;
            in_a1 = 1'((i >> 2) & 1); in_b1 = 1'((i >> 1) & 1); in_carry1 = 1'(i & 1);
            in_valid1 = 1'b1;
            tick();
            in_valid1 = 1'b0;
            lat = 0;
            while (!out_valid1 && lat < 8) begin
                tick();
                lat++;
            end
            check("w1_lat", 33'(lat), 33'd1);
            check("w1_sum_carry", {out_carry1, out_sum1}, {carry_tab[i], sum_tab[i]});
            tick();
            check("w1_idle", 33'(in_ready1), 33'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand/sum width in bits; legal range 1..32.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand pair offered.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 in_a  input  WIDTH  addend A.
REQ-007 in_b  input  WIDTH  addend B.
REQ-008 in_carry  input  1  carry-in of the operation.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 out_sum  output  WIDTH  sum bits.
REQ-012 out_carry  output  1  final carry-out.

Function
REQ-013 FSM states: IDLE, RUN, DONE; in_ready SHALL be 1 exactly when state is IDLE; out_valid SHALL be 1 exactly when state is DONE.
REQ-014 Accept: on an edge with in_valid && in_ready, capture in_a, in_b and in_carry into the A/B shift registers and the carry flop, clear the bit counter, and go IDLE->RUN.
REQ-015 RUN: each edge SHALL add the current LSBs of A, B and the carry flop through one full-adder instance.
REQ-016 RUN, same edge: shift the sum bit into the MSB of the sum register (right shift), shift A and B right by one, load carry_out into the carry flop, and increment the counter.
REQ-017 RUN SHALL go to DONE on the edge where the counter equals WIDTH-1, so out_valid rises exactly WIDTH cycles after the accept edge.
REQ-018 DONE: out_sum SHALL equal (A+B+cin) mod 2^WIDTH and out_carry SHALL equal bit WIDTH of that sum.
REQ-019 DONE: out_sum and out_carry SHALL hold stable while out_ready is low.
REQ-020 DONE->IDLE on an edge with out_ready high; out_sum/out_carry retain their values until the next result is loaded.
REQ-021 in_valid is ignored outside IDLE; no operand is accepted in the DONE->IDLE cycle, so back-to-back throughput is one result per WIDTH+2 cycles.
REQ-022 WIDTH=1: RUN lasts exactly one cycle; out_carry is the majority of a, b and cin.
REQ-023 The counter SHALL be $clog2(WIDTH)+1 bits wide and SHALL never wrap within one operation.

Reset
REQ-024 While rst_n is low at an edge: state becomes IDLE, and counter, shift registers, carry flop, out_sum and out_carry become 0.
REQ-025 After reset: in_ready=1, out_valid=0.
REQ-026 Reset during RUN or DONE SHALL abort the operation; no out_valid is produced for it.
REQ-027 Reset has priority over an accept or a completion on the same edge.

Structure
REQ-028 The state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL live in the shared package serial_adder_pkg.
REQ-029 The block SHALL instantiate exactly one existing full-adder sub-module, adder (ports a, b, carry_in, sum, carry_out), and SHALL contain no other arithmetic.

Verification
REQ-030 WIDTH=8, A=8'h0F, B=8'h01, cin=0 -> out_sum=8'h10, out_carry=0; out_valid rises 8 cycles after the accept edge.
REQ-031 A=8'hFF, B=8'h01, cin=0 -> out_sum=8'h00, out_carry=1; A=8'hFF, B=8'hFF, cin=1 -> out_sum=8'hFF, out_carry=1.
REQ-032 A=8'h5A, B=8'h3C, out_ready held low 5 cycles in DONE -> out_sum=8'h96, out_carry=0 stable throughout; in_ready=0; IDLE one edge after out_ready rises.
REQ-033 rst_n low for one edge after 3 RUN cycles of 8'hAA+8'h55 -> IDLE next cycle, in_ready=1, out_valid never asserted for that op; a subsequent 8'h01+8'h01 yields 8'h02.
REQ-034 in_valid held high with random operands and out_ready=1 for 100 ops -> every result matches the reference sum, and the accept-to-accept spacing is exactly 10 cycles.
REQ-035 WIDTH=1, all 8 (a,b,cin) combinations -> full-adder truth table, with out_valid 1 cycle after accept.
